// File: rtl/divider32.sv
// -----------------------------------------------------------------------------
// divider32
//
// Iterative 32-bit radix-2 restoring divider for the execute stage. A one-cycle
// start pulse in IDLE launches a division. The quotient and remainder appear
// 33 cycles later for a nonzero divisor, or 1 cycle later when dividing by zero.
// The core stalls while busy is high.
//
// Configuration macro: DIVIDER_SIGNED_EN
//   defined   : is_signed is honoured. Operands are converted to magnitudes
//               and the results are sign-corrected in the FIX state.
//   undefined : every operand is unsigned and is_signed is ignored. No negate
//               logic is built. Latency is the same in both builds.
//
// Ports:
//   clk          in   1   system clock, rising edge
//   resetn       in   1   asynchronous active-low reset
//   start        in   1   division request, sampled only in IDLE
//   is_signed    in   1   two's complement operands, sampled with start
//   a            in  32   dividend, sampled with start
//   b            in  32   divisor, sampled with start
//   busy         out  1   high from the accepting edge until the done edge
//   done         out  1   one-cycle pulse when the results are loaded
//   quotient     out 32   registered quotient, held until the next done
//   remainder    out 32   registered remainder, held until the next done
//   div_by_zero  out  1   set together with done when b was zero
// -----------------------------------------------------------------------------
module divider32 (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  state_t      state;

  // The dividend register doubles as the quotient register. Each step shifts
  // one dividend bit out of the top and one quotient bit in at the bottom.
  logic [31:0] dvd_q;
  logic [31:0] rem_q;
  logic [31:0] dsr_q;
  logic [31:0] orig_a_q;
  logic        zero_q;
  logic [5:0]  step_cnt;

  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] q_final;
  logic [31:0] r_final;

`ifdef DIVIDER_SIGNED_EN
  logic        a_neg;
  logic        b_neg;
  logic        q_neg_q;
  logic        r_neg_q;

  // In signed mode a negative operand is replaced by its magnitude. The
  // magnitude of 0x8000_0000 is 0x8000_0000, which the unsigned core handles
  // correctly, so no special case is needed for the most negative value.
  always_comb begin
    a_neg = is_signed & a[31];
    b_neg = is_signed & b[31];
    a_mag = a_neg ? (~a + 32'd1) : a;
    b_mag = b_neg ? (~b + 32'd1) : b;
  end

  // The quotient sign is sa^sb and the remainder takes the sign of the
  // dividend. This makes the quotient truncate toward zero. The overflow case
  // 0x8000_0000 / -1 wraps back to 0x8000_0000.
  always_comb begin
    q_final = q_neg_q ? (~dvd_q + 32'd1) : dvd_q;
    r_final = r_neg_q ? (~rem_q + 32'd1) : rem_q;
  end
`else
  logic        unused_is_signed;

  assign unused_is_signed = is_signed;
  assign a_mag            = a;
  assign b_mag            = b;
  assign q_final          = dvd_q;
  assign r_final          = rem_q;
`endif

  // One restoring step. The partial remainder is widened to 33 bits before
  // the divisor is subtracted. Its top bit can be set after the shift, and
  // dropping that bit would give the wrong answer for divisors >= 2^31. When
  // the shifted value is at least the divisor, the difference is below 2^32.
  // Otherwise bit 32 of the difference is set. So trial[32] alone decides the
  // quotient bit.
  logic [32:0] shifted;
  logic [32:0] trial;

  always_comb begin
    shifted = {rem_q, dvd_q[31]};
    trial   = shifted - {1'b0, dsr_q};
  end

  // Main controller and datapath. The outputs are registered here, so they
  // move only on the edge that raises done.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      step_cnt    <= 6'd0;
      dvd_q       <= 32'd0;
      rem_q       <= 32'd0;
      dsr_q       <= 32'd0;
      orig_a_q    <= 32'd0;
      zero_q      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= 32'd0;
      remainder   <= 32'd0;
      div_by_zero <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dvd_q    <= a_mag;
            dsr_q    <= b_mag;
            orig_a_q <= a;
            zero_q   <= (b == 32'd0);
            rem_q    <= 32'd0;
            step_cnt <= 6'd0;
            busy     <= 1'b1;
`ifdef DIVIDER_SIGNED_EN
            q_neg_q  <= a_neg ^ b_neg;
            r_neg_q  <= a_neg;
`endif
            // A zero divisor skips the iteration and answers in one cycle.
            state    <= (b == 32'd0) ? FIX : RUN;
          end
        end

        RUN: begin
          dvd_q    <= {dvd_q[30:0], ~trial[32]};
          rem_q    <= trial[32] ? shifted[31:0] : trial[31:0];
          step_cnt <= step_cnt + 6'd1;
          // The counter starts at 0, so a value of 31 means this is step 32.
          if (step_cnt == 6'd31) begin
            state <= FIX;
          end
        end

        FIX: begin
          if (zero_q) begin
            quotient    <= 32'hFFFF_FFFF;
            remainder   <= orig_a_q;
            div_by_zero <= 1'b1;
          end else begin
            quotient    <= q_final;
            remainder   <= r_final;
            div_by_zero <= 1'b0;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/divider32.md
# divider32

Iterative 32-bit divider, the inverse companion to the combinational ALU's multiply path. The CPU core issues a division with a one-cycle `start` pulse and receives quotient and remainder after a fixed latency. Each cycle performs one radix-2 restoring step, so the block trades latency for area on the iCE40UP5K. It sits beside the ALU in the execute stage and stalls the core while `busy` is high.

## Interface

Parameters: none (width fixed at 32).

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a division; sampled only in IDLE.
- `is_signed`  in  1  treat `a`/`b` as two's complement; sampled with `start`.
- `a`  in  32  dividend; sampled with `start`.
- `b`  in  32  divisor; sampled with `start`.
- `busy`  out  1  high from the edge accepting `start` until the edge asserting `done`.
- `done`  out  1  one-cycle pulse; results valid from this cycle on.
- `quotient`  out  32  registered quotient; held until the next `done`.
- `remainder`  out  32  registered remainder; held until the next `done`.
- `div_by_zero`  out  1  registered; set with `done` when `b` was 0; held like the results.

## Operation

- States: IDLE, RUN, FIX.
- IDLE, `start`=1:
  - Latch |a|, |b| (magnitudes only if signed mode is active), the sign of the quotient (sa^sb) and the sign of the remainder (sa).
  - Clear the 32-bit partial remainder and the 6-bit step counter.
  - If `b`==0: go to FIX. Otherwise go to RUN.
- RUN, each edge:
  - Shift {rem, dividend} left by 1.
  - trial = rem − divisor, computed 33 bits wide.
  - If trial[32]==0: rem=trial[31:0] and shift in quotient bit 1; else keep rem and shift in 0.
  - Increment the counter; after the 32nd step go to FIX.
- FIX, one edge:
  - Divide by zero: `quotient`=0xFFFF_FFFF, `remainder`=original `a`, `div_by_zero`=1.
  - Otherwise: negate the quotient if its sign flag is set and negate the remainder if its sign flag is set, then load the outputs; `div_by_zero`=0.
  - Pulse `done` and return to IDLE.
- Signed overflow 0x8000_0000 / 0xFFFF_FFFF gives quotient 0x8000_0000, remainder 0 (natural wrap; no flag).
- `start` while busy: ignored; the operation in flight is unaffected.
- `start` in the cycle `done` is high: accepted, because the state is already IDLE.
- The remainder sign follows the dividend; the quotient truncates toward zero.

## Timing

- Reset (asynchronous, `resetn`=0): state IDLE, counter 0. `busy`, `done` and `div_by_zero` go to 0; `quotient` and `remainder` go to 0x0000_0000.
- Reset mid-operation aborts the division immediately; no `done` is produced.
- `start` accepted at edge T; `busy`=1 after edge T.
- Normal division: steps on edges T+1..T+32; FIX at edge T+33. `done`=1 and `busy`=0 between edges T+33 and T+34. Start-to-done latency is 33 cycles.
- Divide by zero: FIX at edge T+1, so `done` follows 1 cycle after acceptance.
- `done` is exactly one cycle wide. The outputs change only on the edge that asserts `done`.

## Configuration

- `DIVIDER_SIGNED_EN` defined:
  - `is_signed` is honoured.
  - Magnitude conversion and sign fix-up are built in.
- Not defined:
  - `is_signed` is ignored and all operands are unsigned.
  - The negate logic is removed.
  - Latency is unchanged.
  - 0xFFFF_FFF9 / 2 → quotient 0x7FFF_FFFC, remainder 1.

## Test plan

- Unsigned 100/7, `start` at T → `done` at T+33 with quotient 14, remainder 2; `busy` high for exactly 33 cycles.
- Divide by zero, a=0x1234_5678, b=0 → `done` after 1 cycle; quotient 0xFFFF_FFFF, remainder 0x1234_5678, `div_by_zero`=1.
- Signed (macro on), −7/2 → quotient 0xFFFF_FFFD (−3), remainder 0xFFFF_FFFF (−1). Then 0x8000_0000 / −1 → quotient 0x8000_0000, remainder 0.
- A second `start` (a=9, b=3) at T+10 during 100/7 → ignored; result 14 r 2. Then a `start` in the `done` cycle → accepted, and its own `done` follows 33 cycles later.
- `resetn` pulsed low at T+15 → all outputs 0 immediately, no `done` pulse. A new 0xFFFF_FFFF/1 completes normally with quotient 0xFFFF_FFFF, remainder 0.
- Back-to-back: 1000 random unsigned pairs (b≠0) are checked against a/b and a%b. Each result holds until the next `done`.
